arm7tdmi_operand2_seq: RTL

ARM7TDMI_OPERAND2_SEQ -- requirements
Module: arm7tdmi_operand2_seq

---
 rtl/arm7tdmi_operand2_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/arm7tdmi_operand2_seq.sv
// Operand-2 sequencer for an ARM7TDMI-style data-processing datapath.
// Accepts one request, optionally reads Rs for a register-specified shift,
// then forms operand 2 and the shifter carry. An external barrel shifter is
// used only where the architecture needs real shifting; all special cases
// (amount 0, amounts of 32 and above, unrotated immediates) are generated here.
module arm7tdmi_operand2_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_imm,
  input  logic        req_reg_shift,
  input  logic [31:0] req_rm_data,
  input  logic [7:0]  req_imm8,
  input  logic [3:0]  req_rot,
  input  logic [1:0]  req_shift_type,
  input  logic [4:0]  req_shift_imm,
  input  logic [3:0]  req_rs_idx,
  input  logic        req_carry_in,
  output logic        rs_rd_en,
  output logic [3:0]  rs_addr,
  input  logic [31:0] rs_data,
  output logic [31:0] sh_data,
  output logic [1:0]  sh_type,
  output logic [4:0]  sh_amount,
  output logic        sh_carry,
  input  logic [31:0] sh_result,
  input  logic        sh_carry_out,
  output logic        op2_valid,
  input  logic        op2_ready,
  output logic [31:0] op2_data,
  output logic        op2_carry,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRsRead, StExec, StHold} state_e;

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  state_e      r_state;
  state_e      w_state_next;
  state_e      w_accept_next;
  logic        w_accept;

  logic        r_imm;
  logic        r_reg_shift;
  logic [31:0] r_rm;
  logic [7:0]  r_imm8;
  logic [3:0]  r_rot;
  logic [1:0]  r_type;
  logic [4:0]  r_shimm;
  logic [3:0]  r_rs_idx;
  logic        r_cin;
  logic [7:0]  r_amt;
  logic [31:0] r_op2_data;
  logic        r_op2_carry;

  logic        w_use_sh;
  logic        w_carry_from_msb;
  logic [31:0] w_loc_data;
  logic        w_loc_carry;
  logic        w_unused_rs;

  // Only the low byte of Rs is a shift amount.
  assign w_unused_rs = ^rs_data[31:8];

  assign req_ready = (r_state == StIdle) || ((r_state == StHold) && op2_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_accept_next = (req_reg_shift && !req_imm) ? StRsRead : StExec;

  assign rs_rd_en  = (r_state == StRsRead);
  assign rs_addr   = r_rs_idx;
  assign op2_valid = (r_state == StHold);
  assign busy      = (r_state != StIdle);
  assign op2_data  = r_op2_data;
  assign op2_carry = r_op2_carry;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a HOLD that drains can accept the next request in the same cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = w_accept_next;
      StRsRead: w_state_next = StExec;
      StExec:   w_state_next = StHold;
      StHold: begin
        if (op2_ready) w_state_next = req_valid ? w_accept_next : StIdle;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  // Request capture and Rs amount capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imm       <= 1'b0;
      r_reg_shift <= 1'b0;
      r_rm        <= '0;
      r_imm8      <= '0;
      r_rot       <= '0;
      r_type      <= '0;
      r_shimm     <= '0;
      r_rs_idx    <= '0;
      r_cin       <= 1'b0;
      r_amt       <= '0;
    end else begin
      if (w_accept) begin
        r_imm       <= req_imm;
        r_reg_shift <= req_reg_shift;
        r_rm        <= req_rm_data;
        r_imm8      <= req_imm8;
        r_rot       <= req_rot;
        r_type      <= req_shift_type;
        r_shimm     <= req_shift_imm;
        r_rs_idx    <= req_rs_idx;
        r_cin       <= req_carry_in;
      end
      if (r_state == StRsRead) r_amt <= rs_data[7:0];
    end
  end

  // Decode the captured request into either a shifter command or a local result.
  always_comb begin
    sh_data          = r_rm;
    sh_type          = r_type;
    sh_amount        = r_shimm;
    sh_carry         = r_cin;
    w_use_sh         = 1'b0;
    w_carry_from_msb = 1'b0;
    w_loc_data       = r_rm;
    w_loc_carry      = r_cin;
    if (r_imm) begin
      if (r_rot == 4'd0) begin
        w_loc_data  = {24'd0, r_imm8};
        w_loc_carry = r_cin;
      end else begin
        // Rotated immediate: carry is bit 31 of the rotated value.
        sh_data          = {24'd0, r_imm8};
        sh_type          = ShRor;
        sh_amount        = {r_rot, 1'b0};
        w_use_sh         = 1'b1;
        w_carry_from_msb = 1'b1;
      end
    end else if (!r_reg_shift) begin
      if (r_shimm == 5'd0) begin
        unique case (r_type)
          ShLsl: begin
            w_loc_data  = r_rm;
            w_loc_carry = r_cin;
          end
          ShLsr: begin
            w_loc_data  = 32'd0;
            w_loc_carry = r_rm[31];
          end
          ShAsr: begin
            w_loc_data  = {32{r_rm[31]}};
            w_loc_carry = r_rm[31];
          end
          default: begin
            // ROR #0 encodes RRX; the shifter performs it with amount 0.
            sh_type   = ShRor;
            sh_amount = 5'd0;
            w_use_sh  = 1'b1;
          end
        endcase
      end else begin
        w_use_sh = 1'b1;
      end
    end else begin
      sh_amount = r_amt[4:0];
      if (r_amt == 8'd0) begin
        w_loc_data  = r_rm;
        w_loc_carry = r_cin;
      end else if (r_amt < 8'd32) begin
        w_use_sh = 1'b1;
      end else begin
        unique case (r_type)
          ShLsl: begin
            w_loc_data  = 32'd0;
            w_loc_carry = (r_amt == 8'd32) ? r_rm[0] : 1'b0;
          end
          ShLsr: begin
            w_loc_data  = 32'd0;
            w_loc_carry = (r_amt == 8'd32) ? r_rm[31] : 1'b0;
          end
          ShAsr: begin
            w_loc_data  = {32{r_rm[31]}};
            w_loc_carry = r_rm[31];
          end
          default: begin
            if (r_amt[4:0] == 5'd0) begin
              w_loc_data  = r_rm;
              w_loc_carry = r_rm[31];
            end else begin
              w_use_sh = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Result register, loaded in EXEC and held through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op2_data  <= '0;
      r_op2_carry <= 1'b0;
    end else if (r_state == StExec) begin
      if (w_use_sh) begin
        r_op2_data  <= sh_result;
        r_op2_carry <= w_carry_from_msb ? sh_result[31] : sh_carry_out;
      end else begin
        r_op2_data  <= w_loc_data;
        r_op2_carry <= w_loc_carry;
      end
    end
  end

endmodule
